// File: rtl/flt_field_unpack.sv
// flt_field_unpack: multi-cycle Start/Done unpacker for a parametrised
// binary float {sign, exp[EXP_W], frac[MAN_W]}. It returns the sign, the
// de-biased exponent, the significand with its hidden bit and a class flag.
// Subnormals are normalised one bit per cycle.
// Optional build macro INT_CONVERT_EN adds a CONV state and the saturating
// integer outputs int_out / sat.
module flt_field_unpack #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   flt_in,
  output logic                   busy,
  output logic                   done,
  output logic                   sign,
  output logic [EXP_W:0]         exp,
  output logic [MAN_W:0]         mant,
  output logic                   is_zero,
  output logic                   is_sub,
  output logic                   is_inf,
  output logic                   is_nan
`ifdef INT_CONVERT_EN
  ,
  output logic signed [INT_W-1:0] int_out,
  output logic                    sat
`endif
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam logic [EXP_W:0] BIAS_V  = (EXP_W+1)'(BIAS);
  localparam logic [EXP_W:0] EXP_INF = (EXP_W+1)'(BIAS + 1);
  localparam logic [EXP_W:0] EXP_SUB = (EXP_W+1)'(1 - BIAS);
  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

  // The smallest subnormal exponent (1-BIAS-MAN_W) must fit in EXP_W+1 bits.
  if (BIAS + MAN_W - 1 > 2**EXP_W) begin : g_bad_range
    $fatal(1, "flt_field_unpack: BIAS+MAN_W-1 exceeds 2**EXP_W");
  end
  if (INT_W < 2 || EXP_W < 2 || MAN_W < 1) begin : g_bad_width
    $fatal(1, "flt_field_unpack: field widths too small");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_NORM,
`ifdef INT_CONVERT_EN
    S_CONV,
`endif
    S_DONE
  } state_t;

  // State entered once the fields are final (decode or normalisation done).
`ifdef INT_CONVERT_EN
  localparam state_t S_POST = S_CONV;
`else
  localparam state_t S_POST = S_DONE;
`endif

  state_t state_reg, state_next;

  logic [EXP_W+MAN_W:0] flt_reg, flt_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 sign_reg, sign_next;
  logic [EXP_W:0]       exp_reg, exp_next;
  logic [MAN_W:0]       mant_reg, mant_next;
  logic                 zero_reg, zero_next;
  logic                 sub_reg, sub_next;
  logic                 inf_reg, inf_next;
  logic                 nan_reg, nan_next;
`ifdef INT_CONVERT_EN
  logic signed [INT_W-1:0] int_reg, int_next;
  logic                    sat_reg, sat_next;
  logic [INT_W-1:0]        conv_mag;
`endif

  logic             fld_sign;
  logic [EXP_W-1:0] fld_exp;
  logic [MAN_W-1:0] fld_frac;

  assign fld_sign = flt_reg[EXP_W+MAN_W];
  assign fld_exp  = flt_reg[MAN_W +: EXP_W];
  assign fld_frac = flt_reg[MAN_W-1:0];

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath next values; every field holds unless updated.
  always_comb begin
    state_next = state_reg;
    flt_next   = flt_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    sign_next  = sign_reg;
    exp_next   = exp_reg;
    mant_next  = mant_reg;
    zero_next  = zero_reg;
    sub_next   = sub_reg;
    inf_next   = inf_reg;
    nan_next   = nan_reg;
`ifdef INT_CONVERT_EN
    int_next   = int_reg;
    sat_next   = sat_reg;
    conv_mag   = INT_W'(({{INT_W{1'b0}}, mant_reg} << exp_reg[EXP_W-1:0]) >> MAN_W);
`endif
    case (state_reg)
      S_IDLE: begin
        // Busy falls together with the Done pulse unless a new request lands.
        if (done_reg) begin
          busy_next = 1'b0;
        end
        if (start) begin
          flt_next   = flt_in;
          busy_next  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        sign_next  = fld_sign;
        zero_next  = 1'b0;
        sub_next   = 1'b0;
        inf_next   = 1'b0;
        nan_next   = 1'b0;
        state_next = S_POST;
        if (fld_exp == '1) begin
          exp_next  = EXP_INF;
          mant_next = {1'b0, fld_frac};
          if (fld_frac == '0) begin
            inf_next = 1'b1;
          end else begin
            nan_next = 1'b1;
          end
        end else if (fld_exp == '0) begin
          if (fld_frac == '0) begin
            zero_next = 1'b1;
            exp_next  = '0;
            mant_next = '0;
          end else begin
            sub_next   = 1'b1;
            exp_next   = EXP_SUB;
            mant_next  = {1'b0, fld_frac};
            state_next = S_NORM;
          end
        end else begin
          exp_next  = {1'b0, fld_exp} - BIAS_V;
          mant_next = {1'b1, fld_frac};
        end
      end
      S_NORM: begin
        // Shift until the hidden-bit position is occupied; frac is non-zero.
        mant_next = {mant_reg[MAN_W-1:0], 1'b0};
        exp_next  = exp_reg - EXP_ONE;
        if (mant_reg[MAN_W-1]) begin
          state_next = S_POST;
        end
      end
`ifdef INT_CONVERT_EN
      S_CONV: begin
        state_next = S_DONE;
        if (nan_reg) begin
          int_next = '0;
          sat_next = 1'b1;
        end else if (inf_reg || ($signed(exp_reg) >= INT_W - 1)) begin
          int_next = sign_reg ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
          sat_next = 1'b1;
        end else if (zero_reg || exp_reg[EXP_W]) begin
          int_next = '0;
          sat_next = 1'b0;
        end else begin
          int_next = sign_reg ? -$signed(conv_mag) : $signed(conv_mag);
          sat_next = 1'b0;
        end
      end
`endif
      S_DONE: begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers; all clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      sign_reg <= 1'b0;
      exp_reg  <= '0;
      mant_reg <= '0;
      zero_reg <= 1'b0;
      sub_reg  <= 1'b0;
      inf_reg  <= 1'b0;
      nan_reg  <= 1'b0;
`ifdef INT_CONVERT_EN
      int_reg  <= '0;
      sat_reg  <= 1'b0;
`endif
    end else begin
      flt_reg  <= flt_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
      sign_reg <= sign_next;
      exp_reg  <= exp_next;
      mant_reg <= mant_next;
      zero_reg <= zero_next;
      sub_reg  <= sub_next;
      inf_reg  <= inf_next;
      nan_reg  <= nan_next;
`ifdef INT_CONVERT_EN
      int_reg  <= int_next;
      sat_reg  <= sat_next;
`endif
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign sign    = sign_reg;
  assign exp     = exp_reg;
  assign mant    = mant_reg;
  assign is_zero = zero_reg;
  assign is_sub  = sub_reg;
  assign is_inf  = inf_reg;
  assign is_nan  = nan_reg;
`ifdef INT_CONVERT_EN
  assign int_out = int_reg;
  assign sat     = sat_reg;
`endif

endmodule

// File: tb/tb_flt_field_unpack.sv
// tb_flt_field_unpack: directed-vector bench for flt_field_unpack with the
// default half-precision parameters. Also builds with INT_CONVERT_EN.
module tb_flt_field_unpack;

`ifdef INT_CONVERT_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] flt_in = '0;
  logic        busy, done, sign;
  logic [5:0]  exp;
  logic [10:0] mant;
  logic        is_zero, is_sub, is_inf, is_nan;
`ifdef INT_CONVERT_EN
  logic signed [15:0] int_out;
  logic               sat;
`endif

  int n_vec = 0;
  int n_bad = 0;

  flt_field_unpack #(.EXP_W(5), .MAN_W(10), .INT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flt_in(flt_in),
    .busy(busy), .done(done), .sign(sign), .exp(exp), .mant(mant),
    .is_zero(is_zero), .is_sub(is_sub), .is_inf(is_inf), .is_nan(is_nan)
`ifdef INT_CONVERT_EN
    , .int_out(int_out), .sat(sat)
`endif
  );

  always #5 clk = ~clk;

  // Issue one request; lat = edges after the accept edge until done, -1 on timeout.
  task automatic run_op(input logic [15:0] v, output int lat);
    @(negedge clk);
    flt_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    $display("op flt_in=%h lat=%0d sign=%b exp=%h mant=%h flags(z,s,i,n)=%b%b%b%b",
             v, lat, sign, exp, mant, is_zero, is_sub, is_inf, is_nan);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 00", {busy, done});
    end
    n_vec++;
    if ({sign, exp, mant} !== 18'h0) begin
      n_bad++; $display("FAIL reset_fields got %h want 0", {sign, exp, mant});
    end
    n_vec++;
    if ({is_zero, is_sub, is_inf, is_nan} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {is_zero, is_sub, is_inf, is_nan});
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_normal();
    int lat;
    run_op(16'h3C00, lat);
    n_vec++;
    if (lat !== 2 + EXTRA) begin
      n_bad++; $display("FAIL norm_lat got %0d want %0d", lat, 2 + EXTRA);
    end
    n_vec++;
    if ({sign, exp, mant} !== {1'b0, 6'h00, 11'h400}) begin
      n_bad++; $display("FAIL norm_3c00 got %b/%h/%h want 0/00/400", sign, exp, mant);
    end
    n_vec++;
    if ({is_zero, is_sub, is_inf, is_nan, busy} !== 5'b00001) begin
      n_bad++; $display("FAIL norm_flags_busy got %b want 00001", {is_zero, is_sub, is_inf, is_nan, busy});
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL norm_after got busy/done %b want 00", {busy, done});
    end
    run_op(16'hC200, lat);
    n_vec++;
    if (lat !== 2 + EXTRA) begin
      n_bad++; $display("FAIL c200_lat got %0d want %0d", lat, 2 + EXTRA);
    end
    n_vec++;
    if ({sign, exp, mant} !== {1'b1, 6'h01, 11'h600}) begin
      n_bad++; $display("FAIL c200 got %b/%h/%h want 1/01/600", sign, exp, mant);
    end
    n_vec++;
    if ({is_zero, is_sub, is_inf, is_nan} !== 4'b0000) begin
      n_bad++; $display("FAIL c200_flags got %b want 0000", {is_zero, is_sub, is_inf, is_nan});
    end
`ifdef INT_CONVERT_EN
    n_vec++;
    if ({int_out, sat} !== {16'hFFFD, 1'b0}) begin
      n_bad++; $display("FAIL c200_int got %0d/%b want -3/0", int_out, sat);
    end
`endif
  endtask

  task automatic test_subnormal();
    int lat;
    run_op(16'h0001, lat);
    n_vec++;
    if (lat !== 12 + EXTRA) begin
      n_bad++; $display("FAIL sub_lat got %0d want %0d", lat, 12 + EXTRA);
    end
    n_vec++;
    if ({sign, exp, mant} !== {1'b0, 6'h28, 11'h400}) begin
      n_bad++; $display("FAIL sub_0001 got %b/%h/%h want 0/28/400", sign, exp, mant);
    end
    n_vec++;
    if ({is_zero, is_sub, is_inf, is_nan} !== 4'b0100) begin
      n_bad++; $display("FAIL sub_flags got %b want 0100", {is_zero, is_sub, is_inf, is_nan});
    end
`ifdef INT_CONVERT_EN
    n_vec++;
    if ({int_out, sat} !== {16'h0000, 1'b0}) begin
      n_bad++; $display("FAIL sub_int got %0d/%b want 0/0", int_out, sat);
    end
`endif
  endtask

  // Start held high across inf, NaN and -0: one accept per Done, in order.
  task automatic test_back_to_back();
    logic [15:0] vin  [3] = '{16'h7C00, 16'h7E00, 16'h8000};
    logic [17:0] vfld [3] = '{{1'b0, 6'h10, 11'h000}, {1'b0, 6'h10, 11'h200}, {1'b1, 6'h00, 11'h000}};
    logic [3:0]  vflg [3] = '{4'b0010, 4'b0001, 4'b1000};
`ifdef INT_CONVERT_EN
    logic [16:0] vint [3] = '{{16'h7FFF, 1'b1}, {16'h0000, 1'b1}, {16'h0000, 1'b0}};
`endif
    int lat, want;
    @(negedge clk);
    flt_in = vin[0];
    start  = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat = k;
          break;
        end
      end
      $display("b2b flt_in=%h lat=%0d sign=%b exp=%h mant=%h flags(z,s,i,n)=%b%b%b%b busy=%b",
               vin[i], lat, sign, exp, mant, is_zero, is_sub, is_inf, is_nan, busy);
      want = (i == 0) ? 2 + EXTRA : 3 + EXTRA;
      n_vec++;
      if (lat !== want) begin
        n_bad++; $display("FAIL b2b_lat[%0d] got %0d want %0d", i, lat, want);
      end
      n_vec++;
      if ({sign, exp, mant} !== vfld[i]) begin
        n_bad++; $display("FAIL b2b_fields[%0d] got %h want %h", i, {sign, exp, mant}, vfld[i]);
      end
      n_vec++;
      if ({is_zero, is_sub, is_inf, is_nan} !== vflg[i]) begin
        n_bad++; $display("FAIL b2b_flags[%0d] got %b want %b", i, {is_zero, is_sub, is_inf, is_nan}, vflg[i]);
      end
`ifdef INT_CONVERT_EN
      n_vec++;
      if ({int_out, sat} !== vint[i]) begin
        n_bad++; $display("FAIL b2b_int[%0d] got %h want %h", i, {int_out, sat}, vint[i]);
      end
`endif
      if (i < 2) begin
        flt_in = vin[i + 1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_idle got busy/done %b want 00", {busy, done});
    end
  endtask

`ifdef INT_CONVERT_EN
  task automatic test_int_convert();
    logic [15:0] vin  [3] = '{16'h7BC0, 16'hF380, 16'h3400};
    logic [16:0] vint [3] = '{{16'h7FFF, 1'b1}, {16'hC400, 1'b0}, {16'h0000, 1'b0}};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(vin[i], lat);
      n_vec++;
      if (lat !== 3) begin
        n_bad++; $display("FAIL conv_lat[%0d] got %0d want 3", i, lat);
      end
      n_vec++;
      if ({int_out, sat} !== vint[i]) begin
        n_bad++; $display("FAIL conv_int[%0d] got %0d/%b want %h", i, int_out, sat, vint[i]);
      end
    end
  endtask
`endif

  // Reset mid-normalisation drops the request; the next request is clean.
  task automatic test_abort();
    int lat;
    int n_done = 0;
    @(negedge clk);
    flt_in = 16'h0001;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("abort reset asserted busy=%b done=%b", busy, done);
    n_vec++;
    if ({busy, done, sign, exp, mant, is_zero, is_sub, is_inf, is_nan} !== 24'h0) begin
      n_bad++; $display("FAIL abort_clear got %h want 0",
                        {busy, done, sign, exp, mant, is_zero, is_sub, is_inf, is_nan});
    end
`ifdef INT_CONVERT_EN
    n_vec++;
    if ({int_out, sat} !== 17'h0) begin
      n_bad++; $display("FAIL abort_int got %h want 0", {int_out, sat});
    end
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    n_vec++;
    if ({n_done, busy} !== {32'd0, 1'b0}) begin
      n_bad++; $display("FAIL abort_nodone got done_count=%0d busy=%b want 0/0", n_done, busy);
    end
    run_op(16'h3C00, lat);
    n_vec++;
    if ({lat, sign, exp, mant} !== {2 + EXTRA, 1'b0, 6'h00, 11'h400}) begin
      n_bad++; $display("FAIL abort_recover got lat=%0d %b/%h/%h want %0d 0/00/400",
                        lat, sign, exp, mant, 2 + EXTRA);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_subnormal();
    test_back_to_back();
`ifdef INT_CONVERT_EN
    test_int_convert();
`endif
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/flt_field_unpack.md
Name: flt_field_unpack

Overview:
- Multi-cycle unpacker for a parametrised IEEE-style binary float (1 sign bit, EXP_W exponent bits, MAN_W fraction bits).
- Produces the sign, the de-biased signed exponent and the significand with the hidden bit restored.
- Classifies the input as zero, subnormal, infinity or NaN, and normalises subnormals one bit per cycle.
- Sits beside the core as a Start/Done coprocessor; it replaces the software field-extraction routine.

Parameters:
- EXP_W, 5, exponent field width. BIAS = 2**(EXP_W-1)-1 is derived internally.
- MAN_W, 10, fraction field width.
- INT_W, 16, integer result width; used only with INT_CONVERT_EN.
- Elaboration constraint: BIAS+MAN_W-1 <= 2**EXP_W. Violation is a fatal error.

Ports:
- Clk, in, 1, rising-edge clock.
- Reset, in, 1, reset; asynchronous, active-low.
- Start, in, 1, request; sampled only in IDLE.
- FltIn, in, 1+EXP_W+MAN_W, packed float {sign, exp, frac}; sampled on the accepting edge.
- Busy, out, 1, high from the accept edge until Done drops.
- Done, out, 1, one-cycle completion pulse.
- Sign, out, 1, sign bit.
- Exp, out, EXP_W+1, de-biased exponent, two's complement.
- Mant, out, MAN_W+1, significand; MSB is the hidden bit.
- IsZero / IsSub / IsInf / IsNan, out, 1 each, class flags; one-hot or all zero.

Behaviour:
- Reset low, even mid-operation: state goes to IDLE immediately. Busy, Done, Sign, Exp, Mant, all flags (and IntOut/Sat when present) clear to 0. The in-flight request is dropped and no Done is issued.
- States: IDLE, DECODE, NORM, [CONV], DONE. All outputs are registered.
- IDLE:
  - Start=1 at an edge latches FltIn, goes to DECODE, and sets Busy.
  - Start while not in IDLE is ignored; no queueing.
- DECODE (1 cycle). E = raw exponent, F = raw fraction.
  - E all-ones, F=0: IsInf=1, Exp=BIAS+1, Mant=0.
  - E all-ones, F!=0: IsNan=1, Exp=BIAS+1, Mant={0,F}.
  - E=0, F=0: IsZero=1, Exp=0, Mant=0. Sign is preserved.
  - E=0, F!=0: IsSub=1, Exp=1-BIAS, Mant={0,F}; go to NORM.
  - Otherwise: Exp=E-BIAS, Mant={1,F}.
  - All cases except subnormal go to CONV if present, else DONE.
- NORM (subnormal only):
  - Each cycle: Mant<<=1, Exp-=1.
  - Leave for CONV/DONE in the cycle where the shifted Mant MSB is 1.
  - Takes lz(F)+1 cycles, where lz counts leading zeros of the MAN_W-bit F; at most MAN_W cycles.
  - The final Mant MSB is always 1.
  - IsSub stays 1 after normalisation.
- DONE: Done=1 for exactly one cycle, then IDLE. Busy drops with Done.
- Output validity:
  - Sign/Exp/Mant/flags are valid while Done=1 and hold stable until the next accept.
  - During Busy before Done they are unspecified; the bench must not check them.
- Latency, with Start accepted at edge N:
  - Normal/zero/inf/NaN: Done high after edge N+2.
  - Subnormal: Done high after edge N+2+lz(F)+1.
  - Add 1 edge when INT_CONVERT_EN is defined.
- Back-to-back: Start held high continuously is accepted again on the first edge in IDLE, i.e. the edge after Done.

Optional Feature:
- Macro: INT_CONVERT_EN.
- Defined:
  - Adds outputs IntOut (INT_W, signed) and Sat (1).
  - Adds a single-cycle CONV state before DONE.
  - IntOut = Mant * 2**(Exp-MAN_W), truncated toward zero, negated if Sign.
  - Exp < 0 or zero: IntOut=0, Sat=0.
  - Exp >= INT_W-1 or IsInf: IntOut = Sign ? -2**(INT_W-1) : 2**(INT_W-1)-1, Sat=1.
  - IsNan: IntOut=0, Sat=1.
  - Both outputs clear on reset.
- Undefined: IntOut, Sat and CONV do not exist; latencies are as listed above.

Test Plan:
- FltIn=16'h3C00 -> Sign=0, Exp=0, Mant=11'h400, no flags; Done after edge N+2.
- FltIn=16'hC200 -> Sign=1, Exp=1, Mant=11'h600. With macro: IntOut=-3, Sat=0, Done after edge N+3.
- FltIn=16'h0001 -> IsSub=1, Exp=-24, Mant=11'h400; Done after edge N+12 (10 NORM cycles).
- FltIn sequence, checked in order:
  - 16'h7C00 -> IsInf, Exp=16, Mant=0.
  - 16'h7E00 -> IsNan, Mant=11'h200.
  - 16'h8000 -> IsZero, Sign=1, Exp=0.
- With macro:
  - 16'h7BC0 -> IntOut=32767, Sat=1.
  - 16'hF380 -> IntOut=-15360, Sat=0.
  - 16'h3400 (0.25) -> IntOut=0, Sat=0.
- Reset/abort/ignore:
  - 16'h0001 accepted, Reset pulsed low 3 cycles later -> no Done, all outputs 0.
  - Then Start with 16'h3C00 -> normal result.
  - Start held high throughout -> exactly one accept per Done.
